game_seq_ctrl: RTL

//  Central game sequencer for the Basys3 dino game.
//  - Runs the game life cycle: IDLE -> RUN -> DEAD -> OVER -> RUN.
//  - In RUN it generates the dino jump trajectory, crouch, obstacle/cloud scroll ticks, score and speed level.
//  - Sits between debounce/collision logic and the scroll, score and render blocks; its freeze output replaces ad-hoc freeze logic.

---
 rtl/game_seq_ctrl_if.sv | 27 ++
 rtl/game_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl_if.sv
// Bundles the sequencer's input strobes/levels and its registered game outputs.
// master drives the inputs and observes the outputs; slave is the sequencer side.
interface game_seq_ctrl_if;
  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic        collide;
  logic [1:0]  state;
  logic        freeze;
  logic [5:0]  dino_y;
  logic        crouch;
  logic        scroll_tick;
  logic [1:0]  speed_lvl;
  logic [16:0] score;
  logic        game_clr;
  logic [16:0] hiscore;

  modport master (
    output frame_tick, btn_up, btn_down, collide,
    input  state, freeze, dino_y, crouch, scroll_tick, speed_lvl, score, game_clr, hiscore
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, collide,
    output state, freeze, dino_y, crouch, scroll_tick, speed_lvl, score, game_clr, hiscore
  );
endinterface

// File: rtl/game_seq_ctrl.sv
// Dino game sequencer: life cycle, jump trajectory, scroll ticks, score/speed; GAME_HISCORE_EN adds a best-score register.
// Latency: every output registered, 1 clk after the causing input edge or frame_tick.
// Backpressure: none; work is paced by frame_tick and consumers must accept every pulse.
module game_seq_ctrl #(
  parameter int JUMP_MAX     = 48,
  parameter int JUMP_STEP    = 4,
  parameter int HANG_FRAMES  = 4,
  parameter int BASE_DIV     = 4,
  parameter int SCORE_FRAMES = 6,
  parameter int SPEED_STEP   = 100,
  parameter int MAX_LVL      = 3,
  parameter int DEAD_HOLD    = 60
) (
  input logic            clk,
  input logic            rst_n,
  game_seq_ctrl_if.slave bus
);

  localparam int HGW = $clog2(HANG_FRAMES + 1);
  localparam int DVW = $clog2(BASE_DIV + 1);
  localparam int SFW = $clog2(SCORE_FRAMES + 1);
  localparam int SSW = $clog2(SPEED_STEP + 1);
  localparam int DHW = $clog2(DEAD_HOLD + 1);

  localparam logic [5:0]  JMAX      = 6'(JUMP_MAX);
  localparam logic [5:0]  JSTEP     = 6'(JUMP_STEP);
  localparam logic [16:0] SCORE_MAX = 17'd99999;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2, ST_OVER = 2'd3} game_st_t;
  typedef enum logic [1:0] {JP_GROUND, JP_RISE, JP_HANG, JP_FALL} jump_ph_t;

  game_st_t         st_q, st_nxt;
  jump_ph_t         jp_q, jp_nxt;
  logic [5:0]       dino_q, dino_nxt;
  logic [HGW-1:0]   hang_q, hang_nxt;

  logic             btn_up_q;
  logic             jump_req_q;
  logic [DVW-1:0]   frame_cnt_q;
  logic [DVW-1:0]   div_lim_q;
  logic [SFW-1:0]   score_cnt_q;
  logic [SSW-1:0]   step_cnt_q;
  logic [16:0]      score_q;
  logic [1:0]       speed_q;
  logic [DHW-1:0]   dead_cnt_q;
  logic             scroll_q;
  logic             clr_q;
  logic             freeze_q;
  logic             crouch_q;

  logic             rise, start, run_ok, run_frame, dead_done, jump_go;
  logic             score_wrap, score_inc, lvl_up;
  logic [1:0]       speed_new;

  always_comb begin
    rise      = bus.btn_up & ~btn_up_q;
    start     = rise & ((st_q == ST_IDLE) | (st_q == ST_OVER));
    // A colliding clk freezes everything, even if frame_tick lands on it.
    run_ok    = (st_q == ST_RUN) & ~bus.collide;
    run_frame = run_ok & bus.frame_tick;
    dead_done = (st_q == ST_DEAD) & bus.frame_tick & (dead_cnt_q == DHW'(DEAD_HOLD - 1));

    score_wrap = run_frame & (score_cnt_q == SFW'(SCORE_FRAMES - 1));
    score_inc  = score_wrap & (score_q != SCORE_MAX);
    lvl_up     = score_inc & (step_cnt_q == SSW'(SPEED_STEP - 1)) & (speed_q != 2'(MAX_LVL));
    speed_new  = speed_q + 2'(lvl_up);
  end

  always_comb begin
    st_nxt = st_q;
    case (st_q)
      ST_IDLE: if (start)       st_nxt = ST_RUN;
      ST_RUN:  if (bus.collide) st_nxt = ST_DEAD;
      ST_DEAD: if (dead_done)   st_nxt = ST_OVER;
      ST_OVER: if (start)       st_nxt = ST_RUN;
      default:                  st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    jp_nxt   = jp_q;
    dino_nxt = dino_q;
    hang_nxt = hang_q;
    jump_go  = 1'b0;
    if (start) begin
      jp_nxt   = JP_GROUND;
      dino_nxt = '0;
      hang_nxt = '0;
    end else if (run_frame) begin
      case (jp_q)
        JP_GROUND: begin
          if (jump_req_q) begin
            jp_nxt   = JP_RISE;
            dino_nxt = JSTEP;
            jump_go  = 1'b1;
          end
        end
        JP_RISE: begin
          if (dino_q >= JMAX - JSTEP) begin
            jp_nxt   = JP_HANG;
            dino_nxt = JMAX;
            hang_nxt = '0;
          end else begin
            dino_nxt = dino_q + JSTEP;
          end
        end
        JP_HANG: begin
          if (hang_q == HGW'(HANG_FRAMES - 1)) jp_nxt = JP_FALL;
          else                                 hang_nxt = hang_q + 1'b1;
        end
        JP_FALL: begin
          if (dino_q <= JSTEP) begin
            jp_nxt   = JP_GROUND;
            dino_nxt = '0;
          end else begin
            dino_nxt = dino_q - JSTEP;
          end
        end
        default: jp_nxt = JP_GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      jp_q     <= JP_GROUND;
      dino_q   <= '0;
      hang_q   <= '0;
      freeze_q <= 1'b1;
      crouch_q <= 1'b0;
    end else begin
      st_q     <= st_nxt;
      jp_q     <= jp_nxt;
      dino_q   <= dino_nxt;
      hang_q   <= hang_nxt;
      freeze_q <= (st_nxt != ST_RUN);
      crouch_q <= bus.btn_down & (st_nxt == ST_RUN) & (jp_nxt == JP_GROUND);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_up_q    <= 1'b0;
      jump_req_q  <= 1'b0;
      frame_cnt_q <= '0;
      div_lim_q   <= DVW'(BASE_DIV - 1);
      score_cnt_q <= '0;
      step_cnt_q  <= '0;
      score_q     <= '0;
      speed_q     <= '0;
      dead_cnt_q  <= '0;
      scroll_q    <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      btn_up_q <= bus.btn_up;
      clr_q    <= start;
      scroll_q <= 1'b0;
      if (start) begin
        jump_req_q  <= 1'b0;
        frame_cnt_q <= '0;
        div_lim_q   <= DVW'(BASE_DIV - 1);
        score_cnt_q <= '0;
        step_cnt_q  <= '0;
        score_q     <= '0;
        speed_q     <= '0;
        dead_cnt_q  <= '0;
      end else if (run_ok) begin
        // Only a rise seen on the ground arms a jump; airborne rises are dropped.
        if (jump_go)
          jump_req_q <= 1'b0;
        else if (rise && !bus.btn_down && jp_q == JP_GROUND)
          jump_req_q <= 1'b1;
        if (bus.frame_tick) begin
          if (frame_cnt_q >= div_lim_q) begin
            frame_cnt_q <= '0;
            scroll_q    <= 1'b1;
            div_lim_q   <= DVW'(BASE_DIV - 1) - DVW'(speed_new);
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
          if (score_wrap) score_cnt_q <= '0;
          else            score_cnt_q <= score_cnt_q + 1'b1;
          if (score_inc) begin
            score_q    <= score_q + 17'd1;
            step_cnt_q <= (step_cnt_q == SSW'(SPEED_STEP - 1)) ? '0 : step_cnt_q + 1'b1;
          end
          speed_q <= speed_new;
        end
      end else if (st_q == ST_DEAD && bus.frame_tick) begin
        dead_cnt_q <= dead_done ? '0 : dead_cnt_q + 1'b1;
      end
    end
  end

`ifdef GAME_HISCORE_EN
  logic [16:0] hiscore_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hiscore_q <= '0;
    else if (st_q == ST_RUN && bus.collide && score_q > hiscore_q)
      hiscore_q <= score_q;
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = '0;
`endif

  assign bus.state       = st_q;
  assign bus.freeze      = freeze_q;
  assign bus.dino_y      = dino_q;
  assign bus.crouch      = crouch_q;
  assign bus.scroll_tick = scroll_q;
  assign bus.speed_lvl   = speed_q;
  assign bus.score       = score_q;
  assign bus.game_clr    = clr_q;

endmodule
